dac_spi_driver: RTL
===================

// Module: dac_spi_driver
// PURPOSE
//  Downstream stage of the function generator: consumes the ch1/ch2 DDS samples and serialises them
//  to a dual-channel 12-bit SPI DAC (MCP4922-style framing, SPI mode 0). One-entry holding buffer
//  lets the DDS present the next sample pair while the current pair is being shifted out.
// PARAMETERS
//  DATA_W   12  sample width per channel; legal 1..12; left-justified into the 12-bit DAC field, LSBs zero
//  CLK_DIV   4  sys_clk cycles per SCLK half-period; legal >=2, elaboration error otherwise
//  CS_IDLE   2  sys_clk cycles cs_n held high between frames; legal >=1
// PORTS
//  sys_clk_i    in   1       system clock
//  sys_rst_i    in   1       reset, asynchronous, active-high
//  ch1_data_i   in   DATA_W  channel A sample
//  ch2_data_i   in   DATA_W  channel B sample
//  smp_valid_i  in   1       sample pair valid
//  smp_ready_o  out  1       holding buffer empty; pair accepted on valid&&ready at rising edge
//  busy_o       out  1       FSM not IDLE
//  dac_sclk_o   out  1       SPI clock, idles low
//  dac_mosi_o   out  1       SPI data, MSB first
//  dac_cs_n_o   out  1       SPI chip select, active low
//  dac_ldac_n_o out  1       DAC latch strobe, active low (only with DAC_LDAC_EN)
// BEHAVIOUR
//  Clock: one clock (sys_clk_i); reset is asynchronous and active-high (sys_rst_i).
//  Reset values: sclk=0, mosi=0, cs_n=1, ldac_n=1, busy=0, hold empty (smp_ready_o=1), state=IDLE.
//  Reset mid-frame: async abort; cs_n high and sclk low immediately; held and in-flight samples lost.
//  Handshake: on valid&&ready, capture both channels into the hold register; ready drops next cycle.
//   ready rises in the cycle after the FSM moves hold into the shift regs, which happens on IDLE exit.
//   Sample inputs are ignored while ready=0. Upstream must keep data stable until the handshake.
//  Frame (16b): [15] ch sel (0=A, 1=B), [14] BUF=0, [13] GA_n=1, [12] SHDN_n=1, [11:0] data.
//  FSM states and transitions:
//   IDLE: if hold full, load it and go to SETUP_A; else stay.
//   SETUP: cs_n low, CLK_DIV cycles.
//   SHIFT: 16 bits. mosi updates on the SCLK falling edge (first bit on SETUP entry).
//    sclk rises mid-bit and the DAC samples on the rising edge. Bit counter 15->0, SCLK period 2*CLK_DIV.
//   HOLD: sclk low, CLK_DIV cycles, then cs_n high.
//   GAP: CS_IDLE cycles. Channel A frame then goes to channel B; channel B frame goes to LDAC or IDLE.
//  Frame sequence per pair: SETUP->SHIFT->HOLD->GAP for channel A, then the same for channel B.
//  Cycles per pair: 2*(34*CLK_DIV+CS_IDLE) [+2*CLK_DIV with macro]; defaults give 276 (284).
//  Back-to-back: a pair accepted during a transfer starts in the cycle after the GAP/LDAC of the current pair.
//   There is no extra idle cycle beyond that one IDLE cycle.
// CONFIGURATION
//  DAC_LDAC_EN defined:
//   dac_ldac_n_o exists; LDAC state after channel B GAP drives ldac_n low for 2*CLK_DIV cycles.
//   Both channels update simultaneously.
//  DAC_LDAC_EN undefined:
//   no port, no LDAC state; the DAC latches each channel at its cs_n rising edge (board ties LDAC low).
// STRUCTURE
//  Shared defines header: frame bit positions, config-bit constants, FSM state encodings.
//  Sub-module dac_sclk_div: CLK_DIV counter producing single-cycle rise/fall enables.
//   It is cleared on SETUP entry; all logic stays on sys_clk_i (no derived clocks).
// TESTING
//  1 Default params, ch1=0xABC, ch2=0x123 -> mosi frames 0x3ABC then 0xB123.
//    16 sclk rises per frame; cs_n low 34*CLK_DIV=136 cycles per frame; busy 276 cycles.
//  2 Assert sys_rst_i mid-SHIFT of frame A -> cs_n=1 and sclk=0 without waiting for a clock edge.
//    ready=1 after release; no frame B emitted.
//  3 smp_valid_i held high with pairs P0, P1 -> P0 accepted at once.
//    P1 accepted 1 cycle after P0 leaves hold. P1 frame A cs_n falls exactly 1 cycle after P0 GAP ends.
//  4 Third pair P2 offered while P1 is held -> ready=0, P2 not captured until P1 shifts.
//    P2 outputs are correct; changing inputs while ready=0 has no effect.
//  5 DATA_W=10, ch1=0x3FF -> frame A data field 0xFFC (frame 0x3FFC).
//  6 DAC_LDAC_EN defined -> ldac_n low 8 cycles, starting the cycle after frame B GAP. Never low while cs_n is low.
//    Undefined -> build has no ldac port; per-pair time 276 cycles.

Source files
------------

// File: rtl/dac_spi_driver_pkg.sv
// dac_spi_driver_pkg: FSM state encoding, DAC config bits and 16-bit frame builder
package dac_spi_driver_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP, LDAC} state_t;
  localparam int FRAME_W = 16;
  localparam int DAC_W = 12;
  localparam logic CFG_BUF = 1'b0;
  localparam logic CFG_GA_N = 1'b1;
  localparam logic CFG_SHDN_N = 1'b1;
  function automatic logic [FRAME_W-1:0] dac_frame(input logic ch, input logic [DAC_W-1:0] d);
    return {ch, CFG_BUF, CFG_GA_N, CFG_SHDN_N, d};
  endfunction
endpackage

// File: rtl/dac_sclk_div.sv
// dac_sclk_div: CLK_DIV counter giving one-cycle sclk rise/fall enables; ports: sys_clk_i, sys_rst_i, clr (restart, next tick is a fall), rise, fall
module dac_sclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic sys_clk_i,
  input  logic sys_rst_i,
  input  logic clr,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt;
  logic ph;
  logic tick;
  assign tick = cnt == CW'(CLK_DIV - 1);
  assign rise = tick & ~ph;
  assign fall = tick & ph;
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      cnt <= '0;
      ph <= 1'b1;
    end else if (clr) begin
      cnt <= '0;
      ph <= 1'b1;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      ph <= ph ^ tick;
    end
  end
endmodule

// File: rtl/dac_spi_driver.sv
// dac_spi_driver: sample-pair hold buffer + dual-channel 12-bit SPI DAC serialiser (mode 0); ports: sys_clk_i, sys_rst_i (async), ch1/ch2_data_i, smp_valid_i/smp_ready_o, busy_o, dac_sclk/mosi/cs_n_o, dac_ldac_n_o with macro DAC_LDAC_EN
module dac_spi_driver
  import dac_spi_driver_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int CLK_DIV = 4,
  parameter int CS_IDLE = 2
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic [DATA_W-1:0] ch1_data_i,
  input  logic [DATA_W-1:0] ch2_data_i,
  input  logic              smp_valid_i,
  output logic              smp_ready_o,
  output logic              busy_o,
  output logic              dac_sclk_o,
  output logic              dac_mosi_o,
  output logic              dac_cs_n_o
`ifdef DAC_LDAC_EN
  , output logic            dac_ldac_n_o
`endif
);
  if (DATA_W < 1 || DATA_W > DAC_W) begin : g_bad_w
    $error("DATA_W must be 1..12");
  end
  if (CLK_DIV < 2) begin : g_bad_div
    $error("CLK_DIV must be >= 2");
  end
  if (CS_IDLE < 1) begin : g_bad_idle
    $error("CS_IDLE must be >= 1");
  end
  state_t state, nxt;
  logic hold_full, ch, sclk, rise, fall, clr, load, gap_done;
  logic [DAC_W-1:0] hold_a, hold_b, cur_b;
  logic [FRAME_W-1:0] sr;
  logic [3:0] bit_cnt;
  logic [15:0] tmr;
  assign load = state == IDLE && hold_full;
  assign gap_done = tmr == 16'(CS_IDLE - 1);
  // divider restarts on every SETUP entry so each frame starts phase-aligned
  assign clr = nxt == SETUP && state != SETUP;
  dac_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .sys_clk_i(sys_clk_i),
    .sys_rst_i(sys_rst_i),
    .clr(clr),
    .rise(rise),
    .fall(fall)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = hold_full ? SETUP : IDLE;
      SETUP: nxt = fall ? SHIFT : SETUP;
      SHIFT: nxt = fall && bit_cnt == 4'd0 ? HOLD : SHIFT;
      HOLD:  nxt = rise ? GAP : HOLD;
`ifdef DAC_LDAC_EN
      GAP:   nxt = !gap_done ? GAP : !ch ? SETUP : LDAC;
`else
      GAP:   nxt = !gap_done ? GAP : !ch ? SETUP : IDLE;
`endif
      LDAC:  nxt = tmr == 16'(2 * CLK_DIV - 1) ? IDLE : LDAC;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state <= IDLE;
      hold_full <= 1'b0;
      hold_a <= '0;
      hold_b <= '0;
      cur_b <= '0;
      ch <= 1'b0;
      sr <= '0;
      bit_cnt <= 4'd15;
      tmr <= '0;
      sclk <= 1'b0;
    end else begin
      state <= nxt;
      tmr <= nxt != state ? '0 : tmr + 16'd1;
      sclk <= state == SHIFT && (rise || (sclk && !fall));
      if (load) begin
        hold_full <= 1'b0;
      end else if (smp_valid_i && !hold_full) begin
        hold_full <= 1'b1;
        hold_a <= DAC_W'(ch1_data_i) << (DAC_W - DATA_W);
        hold_b <= DAC_W'(ch2_data_i) << (DAC_W - DATA_W);
      end
      if (load) begin
        sr <= dac_frame(1'b0, hold_a);
        cur_b <= hold_b;
        ch <= 1'b0;
        bit_cnt <= 4'd15;
      end else if (state == GAP && gap_done && !ch) begin
        sr <= dac_frame(1'b1, cur_b);
        ch <= 1'b1;
        bit_cnt <= 4'd15;
      end else if (state == SHIFT && fall && bit_cnt != 4'd0) begin
        sr <= {sr[FRAME_W-2:0], 1'b0};
        bit_cnt <= bit_cnt - 4'd1;
      end
    end
  end
  assign smp_ready_o = !hold_full;
  assign busy_o = state != IDLE;
  assign dac_sclk_o = sclk;
  assign dac_mosi_o = sr[FRAME_W-1];
  assign dac_cs_n_o = !(state == SETUP || state == SHIFT || state == HOLD);
`ifdef DAC_LDAC_EN
  assign dac_ldac_n_o = state != LDAC;
`endif
endmodule
